baby_serial_word_tx: RTL
========================

BABY_SERIAL_WORD_TX -- requirements
Module: baby_serial_word_tx

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the serial word length in bits (legal range 2..64).
REQ-002 Parameter GAP_CYCLES, default 1, SHALL set the idle cycles inserted after each word (legal range 0..15).
REQ-003 Parameter OUTPUT_INVERT, default 0, SHALL invert the serial line when 1 (7404-style line driver); 0 means true polarity.
REQ-004 CLK  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-005 RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-006 LOAD_VALID  input  1  high when DATA_IN holds a word to send.
REQ-007 DATA_IN  input  WORD_WIDTH  parallel word; bit 0 is sent first.
REQ-008 LOAD_READY  output  1  high when the block can accept a word this cycle.
REQ-009 SERIAL_OUT  output  1  serial data line, after optional inversion.
REQ-010 BIT_VALID  output  1  high on every cycle that SERIAL_OUT carries a data bit.
REQ-011 WORD_SYNC  output  1  high only on the cycle carrying bit 0 of a word.
REQ-012 BIT_INDEX  output  clog2(WORD_WIDTH)  index of the bit on SERIAL_OUT; 0 when BIT_VALID is low.
REQ-013 BUSY  output  1  high in SHIFT and GAP states.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, GAP.
REQ-015 IDLE: LOAD_READY=1, BUSY=0, BIT_VALID=0, WORD_SYNC=0, raw line=0.
REQ-016 A word SHALL be accepted on a rising edge where LOAD_VALID=1 and LOAD_READY=1: DATA_IN is captured into the shift register and the state moves to SHIFT.
REQ-017 On the cycle after acceptance, SERIAL_OUT SHALL carry DATA_IN[0], with BIT_VALID=1, WORD_SYNC=1 and BIT_INDEX=0 (latency of 1 cycle).
REQ-018 In SHIFT, bit n SHALL be presented for exactly one cycle, n = 0..WORD_WIDTH-1 in ascending order, with BIT_INDEX=n.
REQ-019 After bit WORD_WIDTH-1, the FSM SHALL go to GAP if GAP_CYCLES>0, otherwise straight to IDLE.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles, with BIT_VALID=0, raw line=0 and LOAD_READY=0, then return to IDLE.
REQ-021 LOAD_READY SHALL be 0 in SHIFT and GAP; LOAD_VALID in those states SHALL be ignored (no queue, no error).
REQ-022 Changes on DATA_IN after acceptance SHALL NOT affect the word being sent.
REQ-023 SERIAL_OUT SHALL equal the raw line XOR OUTPUT_INVERT in every state, including reset; no other output is affected by inversion.
REQ-024 The minimum word period SHALL be WORD_WIDTH + GAP_CYCLES + 1 cycles from one acceptance to the next, the extra cycle being the IDLE cycle with LOAD_READY=1.
REQ-025 All outputs SHALL be driven directly from registers (no combinational path from inputs to outputs), except LOAD_READY, which is decoded from state only.

Reset
REQ-026 RESET=1 SHALL force IDLE and clear the shift register and bit counter on that edge: LOAD_READY=1, BUSY=0, BIT_VALID=0, WORD_SYNC=0, BIT_INDEX=0, SERIAL_OUT=OUTPUT_INVERT.
REQ-027 RESET SHALL take priority over LOAD_VALID; a word presented on a reset edge SHALL NOT be accepted.
REQ-028 A reset asserted mid-word or mid-gap SHALL abort the transfer at once, with no further BIT_VALID pulses from that word.

Verification
REQ-029 Defaults; DATA_IN=32'h8000_0001 accepted -> WORD_SYNC=1 and SERIAL_OUT=1 on the next cycle; bits 1..30=0; bit 31=1 with BIT_INDEX=31; then 1 GAP cycle, then LOAD_READY=1.
REQ-030 Back-to-back: LOAD_VALID held high with 32'hA5A5_5A5A then 32'h0000_FFFF -> both words serialised LSB first, with acceptances exactly 34 cycles apart.
REQ-031 LOAD_VALID pulsed with 32'hFFFF_FFFF during SHIFT of 32'h1234_5678 -> pulse ignored; only 32'h1234_5678 is observed and BIT_VALID counts exactly 32.
REQ-032 RESET asserted at BIT_INDEX=10 -> next cycle shows IDLE outputs per REQ-026; a fresh word then starts with WORD_SYNC and bit 0 of the new word.
REQ-033 OUTPUT_INVERT=1, GAP_CYCLES=0, WORD_WIDTH=8, DATA_IN=8'h3C -> SERIAL_OUT sequence 1,1,0,0,0,0,1,1; idle level 1; next acceptance 9 cycles later.
REQ-034 RESET and LOAD_VALID high on the same edge -> no acceptance, BIT_VALID stays 0, LOAD_READY=1 on the following cycle.

Source files
------------

// File: rtl/baby_serial_word_tx.sv
// ---------------------------------------------------------------------------
// baby_serial_word_tx
//
// Parallel-in / serial-out word transmitter. A word offered with LOAD_VALID
// while LOAD_READY is high is captured and sent LSB first, one bit per clock,
// starting on the cycle after acceptance. An optional run of idle GAP cycles
// follows every word, then the block returns to IDLE for at least one cycle
// before it can accept the next word.
//
// Parameters
//   WORD_WIDTH     serial word length in bits (2..64)
//   GAP_CYCLES     idle cycles inserted after each word (0..15)
//   OUTPUT_INVERT  1 inverts the serial line (inverting line driver)
//
// Ports
//   CLK         system clock, all state changes on its rising edge
//   RESET       synchronous active-high reset
//   LOAD_VALID  DATA_IN holds a word to send
//   DATA_IN     parallel word, bit 0 sent first
//   LOAD_READY  block can accept a word this cycle (decoded from state)
//   SERIAL_OUT  serial data line after optional inversion (registered)
//   BIT_VALID   SERIAL_OUT carries a data bit (registered)
//   WORD_SYNC   SERIAL_OUT carries bit 0 of a word (registered)
//   BIT_INDEX   index of the bit on SERIAL_OUT, 0 when idle (registered)
//   BUSY        block is in SHIFT or GAP (registered)
// ---------------------------------------------------------------------------
module baby_serial_word_tx #(
   parameter int WORD_WIDTH    = 32,
   parameter int GAP_CYCLES    = 1,
   parameter int OUTPUT_INVERT = 0
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          LOAD_VALID,
   input  logic [WORD_WIDTH-1:0]         DATA_IN,
   output logic                          LOAD_READY,
   output logic                          SERIAL_OUT,
   output logic                          BIT_VALID,
   output logic                          WORD_SYNC,
   output logic [$clog2(WORD_WIDTH)-1:0] BIT_INDEX,
   output logic                          BUSY
);

   localparam int               IDX_W    = $clog2(WORD_WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);
   localparam logic             INV_BIT  = (OUTPUT_INVERT != 0) ? 1'b1 : 1'b0;
   localparam logic             HAS_GAP  = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;
   // Gap counter is loaded with the number of GAP cycles still to run after
   // the first one, so it reaches zero on the final GAP cycle.
   localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                state_q,     state_d;
   logic [WORD_WIDTH-1:0] shift_q,     shift_d;
   logic [IDX_W-1:0]      bit_cnt_q,   bit_cnt_d;
   logic [3:0]            gap_cnt_q,   gap_cnt_d;
   logic                  serial_q,    serial_d;
   logic                  bit_valid_q, bit_valid_d;
   logic                  word_sync_q, word_sync_d;
   logic                  busy_q,      busy_d;
   logic                  raw_s;

   // Next-state and next-output decode for the IDLE/SHIFT/GAP sequencer.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      raw_s       = 1'b0;
      bit_valid_d = 1'b0;
      word_sync_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (LOAD_VALID) begin
               // Bit 0 goes straight to the output flop; the shift register
               // keeps the remaining bits, next one always in position 0.
               state_d     = ST_SHIFT;
               shift_d     = {1'b0, DATA_IN[WORD_WIDTH-1:1]};
               bit_cnt_d   = '0;
               raw_s       = DATA_IN[0];
               bit_valid_d = 1'b1;
               word_sync_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            // bit_cnt_q is the index currently shown on the line.
            if (bit_cnt_q == LAST_IDX) begin
               bit_cnt_d = '0;
               shift_d   = '0;
               if (HAS_GAP) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = GAP_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               bit_cnt_d   = bit_cnt_q + IDX_W'(1);
               raw_s       = shift_q[0];
               shift_d     = {1'b0, shift_q[WORD_WIDTH-1:1]};
               bit_valid_d = 1'b1;
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
            gap_cnt_d = 4'd0;
         end
      endcase

      busy_d   = (state_d != ST_IDLE);
      serial_d = raw_s ^ INV_BIT;
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= 4'd0;
         serial_q    <= INV_BIT;
         bit_valid_q <= 1'b0;
         word_sync_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         serial_q    <= serial_d;
         bit_valid_q <= bit_valid_d;
         word_sync_q <= word_sync_d;
         busy_q      <= busy_d;
      end
   end

   assign LOAD_READY = (state_q == ST_IDLE);
   assign SERIAL_OUT = serial_q;
   assign BIT_VALID  = bit_valid_q;
   assign WORD_SYNC  = word_sync_q;
   assign BIT_INDEX  = bit_cnt_q;
   assign BUSY       = busy_q;

endmodule
